// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution tile sequencer: tile geometry,
// the FSM state enum, inst bit positions and the quiescent inst word.
package conv_seq_pkg;

    localparam int COL      = 8;
    localparam int ROW      = 8;
    localparam int LEN_KIJ  = 9;
    localparam int LEN_KI   = 3;
    localparam int LEN_NIJ  = 36;
    localparam int LEN_NI   = 6;
    localparam int LEN_ONIJ = 16;
    localparam int LEN_ONI  = 4;
    localparam int W_BASE   = 1024;
    localparam int GAP_CYC  = 16;

    localparam int ADDR_W = 11;
    localparam int INST_W = 34;
    localparam int CNT_W  = 6;

    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP_HI    = 30;
    localparam int B_AP_LO    = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_AX_HI    = 17;
    localparam int B_AX_LO    = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXE      = 1;
    localparam int B_LOAD     = 0;

    // Both SRAMs deselected and write-disabled; every strobe low.
    localparam logic [INST_W-1:0] INST_IDLE = (34'd1 << B_CEN_P) | (34'd1 << B_WEN_P)
                                            | (34'd1 << B_CEN_X) | (34'd1 << B_WEN_X);

    typedef enum logic [3:0] {IDLE, WL0, KLD, GAP, AL0, EXE, DRN, ACC, DONE} state_t;

endpackage

// File: rtl/conv_seq_ctrl_acc_addr_gen.sv
// pmem address of partial sum (kernel position k) contributing to output pixel o.
// Purely combinational; no backpressure.
module acc_addr_gen
    import conv_seq_pkg::*;
(
    input  logic [3:0]        i_o,
    input  logic [3:0]        i_k,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] w_o;
    logic [ADDR_W-1:0] w_k;

    assign w_o = ADDR_W'(i_o);
    assign w_k = ADDR_W'(i_k);

    // Slab of kij k, then the input pixel under kernel tap k for output pixel o.
    assign o_addr = ADDR_W'(LEN_NIJ) * w_k
                  + (w_o / ADDR_W'(LEN_ONI)) * ADDR_W'(LEN_NI) + (w_o % ADDR_W'(LEN_ONI))
                  + (w_k / ADDR_W'(LEN_KI)) * ADDR_W'(LEN_NI) + (w_k % ADDR_W'(LEN_KI));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer emitting the core inst stream for one 3x3 conv tile (optional perf counters: CONV_SEQ_PERF_EN).
// Latency: inst/status registered, one cycle behind each state decision; DRN stalls while ofifo_valid=0.
module conv_seq_ctrl
    import conv_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic              sfp_valid,
    output logic              sfp_clr,
    output logic [3:0]        out_idx,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
);

    localparam logic [CNT_W-1:0] C_COL     = CNT_W'(COL);
    localparam logic [CNT_W-1:0] C_KLD_END = CNT_W'(2 * COL - 2);
    localparam logic [CNT_W-1:0] C_GAP_END = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_NIJ     = CNT_W'(LEN_NIJ);
    localparam logic [CNT_W-1:0] C_EXE_END = CNT_W'(LEN_NIJ - 1);
    localparam logic [CNT_W-1:0] C_KIJ     = CNT_W'(LEN_KIJ);
    localparam logic [CNT_W-1:0] C_SFP     = CNT_W'(LEN_KIJ + 1);
    localparam logic [CNT_W-1:0] C_CLR     = CNT_W'(LEN_KIJ + 2);
    localparam logic [3:0]       C_KIJ_LAST = 4'(LEN_KIJ - 1);
    localparam logic [3:0]       C_O_LAST   = 4'(LEN_ONIJ - 1);

    localparam int MAX_XMEM = W_BASE + LEN_KIJ * COL - 1;
    localparam int MAX_PMEM = LEN_NIJ * LEN_KIJ - 1;

    if (MAX_XMEM >= 2048 || MAX_PMEM >= 2048 || LEN_NIJ + 2 > 2**CNT_W || 2 * COL > 2**CNT_W
        || GAP_CYC > 2**CNT_W || LEN_KIJ + 3 > 16 || LEN_ONIJ > 16 || ROW < 1) begin : g_bad_cfg
        $error("conv_seq_ctrl: tile geometry overflows address or counter widths");
    end

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_n;
    logic [3:0]          r_kij;
    logic [3:0]          r_o;
    logic                r_wr_pend;
    logic [INST_W-1:0]   r_inst;
    logic                r_busy;
    logic                r_done;
    logic                r_sfp_valid;
    logic                r_sfp_clr;
    logic [3:0]          r_out_idx;

    logic [ADDR_W-1:0]   w_acc_addr;
    logic [ADDR_W-1:0]   w_wl0_addr;
    logic [ADDR_W-1:0]   w_drn_addr;
    logic                w_rd_go;

    acc_addr_gen u_acc_addr_gen (
        .i_o    (r_o),
        .i_k    (r_cnt[3:0]),
        .o_addr (w_acc_addr)
    );

    assign w_wl0_addr = ADDR_W'(W_BASE) + ADDR_W'(r_kij) * ADDR_W'(COL) + ADDR_W'(r_cnt);
    assign w_drn_addr = ADDR_W'(r_kij) * ADDR_W'(LEN_NIJ) + ADDR_W'(r_n);
    assign w_rd_go    = (r_state == DRN) && ofifo_valid && (r_cnt < C_NIJ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_n         <= '0;
            r_kij       <= '0;
            r_o         <= '0;
            r_wr_pend   <= 1'b0;
            r_inst      <= INST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sfp_valid <= 1'b0;
            r_sfp_clr   <= 1'b0;
            r_out_idx   <= '0;
        end else begin
            r_inst      <= INST_IDLE;
            r_done      <= 1'b0;
            r_sfp_valid <= 1'b0;
            r_sfp_clr   <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= WL0;
                    r_cnt   <= '0;
                    r_kij   <= '0;
                    r_busy  <= 1'b1;
                end
                WL0: begin
                    if (r_cnt < C_COL) begin
                        r_inst[B_CEN_X]         <= 1'b0;
                        r_inst[B_AX_HI:B_AX_LO] <= w_wl0_addr;
                    end
                    r_inst[B_L0_WR] <= (r_cnt != '0);
                    if (r_cnt == C_COL) begin
                        r_state <= KLD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                KLD: begin
                    r_inst[B_LOAD]  <= (r_cnt < C_COL);
                    r_inst[B_L0_RD] <= (r_cnt < C_COL);
                    if (r_cnt == C_KLD_END) begin
                        r_state <= GAP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == C_GAP_END) begin
                        r_state <= AL0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                AL0: begin
                    if (r_cnt < C_NIJ) begin
                        r_inst[B_CEN_X]         <= 1'b0;
                        r_inst[B_AX_HI:B_AX_LO] <= ADDR_W'(r_cnt);
                    end
                    r_inst[B_L0_WR] <= (r_cnt != '0);
                    if (r_cnt == C_NIJ) begin
                        r_state <= EXE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EXE: begin
                    r_inst[B_EXE]   <= 1'b1;
                    r_inst[B_L0_RD] <= 1'b1;
                    if (r_cnt == C_EXE_END) begin
                        r_state   <= DRN;
                        r_cnt     <= '0;
                        r_n       <= '0;
                        r_wr_pend <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRN: begin
                    // r_cnt counts OFIFO reads issued, r_n the pmem writes that follow them.
                    r_inst[B_OFIFO_RD] <= w_rd_go;
                    r_wr_pend          <= w_rd_go;
                    if (w_rd_go) r_cnt <= r_cnt + 1'b1;
                    if (r_wr_pend) begin
                        r_inst[B_CEN_P]         <= 1'b0;
                        r_inst[B_WEN_P]         <= 1'b0;
                        r_inst[B_AP_HI:B_AP_LO] <= w_drn_addr;
                        r_n                     <= r_n + 1'b1;
                    end
                    if (r_n == C_NIJ) begin
                        r_cnt <= '0;
                        if (r_kij == C_KIJ_LAST) begin
                            r_state <= ACC;
                            r_o     <= '0;
                        end else begin
                            r_state <= WL0;
                            r_kij   <= r_kij + 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (r_cnt < C_KIJ) begin
                        r_inst[B_CEN_P]         <= 1'b0;
                        r_inst[B_AP_HI:B_AP_LO] <= w_acc_addr;
                    end
                    r_inst[B_ACC] <= (r_cnt != '0) && (r_cnt <= C_KIJ);
                    if (r_cnt == C_SFP) begin
                        r_sfp_valid <= 1'b1;
                        r_out_idx   <= r_o;
                    end
                    if (r_cnt == C_CLR) begin
                        r_sfp_clr <= 1'b1;
                        r_cnt     <= '0;
                        if (r_o == C_O_LAST) r_state <= DONE;
                        else                 r_o     <= r_o + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign inst      = r_inst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sfp_valid = r_sfp_valid;
    assign sfp_clr   = r_sfp_clr;
    assign out_idx   = r_out_idx;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (r_state == IDLE && start) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_busy && r_perf_busy != '1) r_perf_busy <= r_perf_busy + 32'd1;
            // Only stalls that delay an outstanding OFIFO read are counted.
            if (r_state == DRN && !ofifo_valid && r_cnt < C_NIJ && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_busy_cyc  = r_perf_busy;
    assign perf_stall_cyc = r_perf_stall;
`else
    assign perf_busy_cyc  = '0;
    assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: event-queue model of the tile's SRAM traffic plus per-cycle strobe checks.
module tb_conv_seq_ctrl;

    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic        sfp_valid;
    logic        sfp_clr;
    logic [3:0]  out_idx;
    logic [31:0] perf_busy_cyc;
    logic [31:0] perf_stall_cyc;

    always #5 clk = ~clk;

    conv_seq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .ofifo_valid    (ofifo_valid),
        .inst           (inst),
        .busy           (busy),
        .done           (done),
        .sfp_valid      (sfp_valid),
        .sfp_clr        (sfp_clr),
        .out_idx        (out_idx),
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    int xrd_q[$];
    int pw_q[$];
    int pr_q[$];
    int sfp_q[$];
    int pr_idx, acc_run, done_cnt, busy_cnt, exec_cnt, load_cnt, pw_cnt;
    int ref_busy = 0;
    logic [33:0] p_inst;
    logic [33:0] cur;
    logic        p_valid;
    logic        p_sfp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got an event the model did not expect, expected none", name);
    endtask

    // Expected SRAM traffic for one tile, built straight from the tile geometry.
    task automatic arm_model();
        xrd_q.delete();
        pw_q.delete();
        pr_q.delete();
        sfp_q.delete();
        for (int kij = 0; kij < 9; kij++) begin
            for (int t = 0; t < 8; t++)  xrd_q.push_back(1024 + 8 * kij + t);
            for (int n = 0; n < 36; n++) xrd_q.push_back(n);
            for (int n = 0; n < 36; n++) pw_q.push_back(36 * kij + n);
        end
        for (int o = 0; o < 16; o++) begin
            sfp_q.push_back(o);
            for (int k = 0; k < 9; k++)
                pr_q.push_back(36 * k + ((o / 4) + (k / 3)) * 6 + ((o % 4) + (k % 3)));
        end
        pr_idx = 0; acc_run = 0; done_cnt = 0; busy_cnt = 0;
        exec_cnt = 0; load_cnt = 0; pw_cnt = 0;
        p_inst = IDLE_INST; p_valid = 1'b0; p_sfp = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cur = inst;
            if (busy) busy_cnt++;
            check("ififo_bits", cur[5:4], 0);
            check("l0_wr_lags_xmem_rd", cur[2], !p_inst[19]);
            check("acc_lags_pmem_rd", cur[33], !p_inst[32] && p_inst[31]);
            check("pmem_wr_follows_ofifo_rd", !cur[32] && !cur[31], p_inst[6]);
            if (cur[6]) check("ofifo_rd_only_when_valid", p_valid, 1);
            if (cur[0] || cur[1]) check("l0_rd_with_load_exec", cur[3], 1);
            if (!cur[19]) begin
                check("xmem_wen_high", cur[18], 1);
                if (xrd_q.size() == 0) miss("xmem_extra_read");
                else check("xmem_addr", cur[17:7], xrd_q.pop_front());
            end
            if (!cur[32]) begin
                if (!cur[31]) begin
                    if (pw_q.size() == 0) miss("pmem_extra_write");
                    else check("pmem_wr_addr", cur[30:20], pw_q.pop_front());
                    pw_cnt++;
                end else begin
                    if (pr_q.size() == 0) miss("pmem_extra_read");
                    else check("pmem_rd_addr", cur[30:20], pr_q.pop_front());
                    if (pr_idx == 5 * 9 + 4) check("acc_addr_o5_k4", cur[30:20], 158);
                    pr_idx++;
                end
            end
            if (cur[33]) acc_run++;
            if (cur[1]) exec_cnt++;
            if (cur[0]) load_cnt++;
            if (sfp_valid) begin
                check("acc_cycles_per_pixel", acc_run, 9);
                acc_run = 0;
                check("sfp_after_last_acc", p_inst[33], 1);
                if (sfp_q.size() == 0) miss("sfp_extra_pixel");
                else check("out_idx", out_idx, sfp_q.pop_front());
            end
            check("sfp_clr_after_valid", sfp_clr, p_sfp);
            if (done) done_cnt++;
            p_inst  = cur;
            p_valid = ofifo_valid;
            p_sfp   = sfp_valid;
        end
    end

    // mode 0: ofifo_valid held 1; mode 1: toggles every cycle.
    task automatic run_tile(input int mode, input bit inject, input bit abort_mid);
        bit injected = 1'b0;
        int tail = 0;
        @(posedge clk); #2;
        arm_model();
        ofifo_valid = (mode == 0);
        chk_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(negedge clk);
        check("busy_rises", busy, 1);
        check("inst_idle_after_start", inst, IDLE_INST);
        @(negedge clk);
        check("first_xmem_addr", inst[17:7], 1024);
        check("first_xmem_cen", inst[19], 0);
        check("l0_wr_not_yet", inst[2], 0);
        @(negedge clk);
        check("l0_wr_one_cycle_later", inst[2], 1);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (mode == 1) ofifo_valid = ~ofifo_valid;
            if (inject && !injected && pw_cnt > 40 && inst[6]) begin
                start = 1'b1;
                injected = 1'b1;
            end
            if (abort_mid && exec_cnt >= 3 * 36 + 10) begin
                chk_en = 1'b0;
                check("pre_reset_executing", inst[1], 1);
                reset = 1'b0;
                #1;
                check("async_reset_inst", inst, IDLE_INST);
                check("async_reset_busy", busy, 0);
                repeat (3) @(posedge clk);
                #2;
                reset = 1'b1;
                @(negedge clk);
                check("post_reset_inst", inst, IDLE_INST);
                return;
            end
            if (done_cnt > 0) tail++;
            if (tail == 20) break;
        end
        chk_en = 1'b0;
        if (done_cnt == 0) miss("done_timeout");
        check("xmem_reads_left", xrd_q.size(), 0);
        check("pmem_writes_left", pw_q.size(), 0);
        check("pmem_reads_left", pr_q.size(), 0);
        check("pixels_left", sfp_q.size(), 0);
        check("pmem_write_count", pw_cnt, 324);
        check("pmem_read_count", pr_idx, 144);
        check("execute_cycles", exec_cnt, 324);
        check("load_cycles", load_cnt, 72);
        check("done_pulses", done_cnt, 1);
        check("busy_low_after_done", busy, 0);
`ifdef CONV_SEQ_PERF_EN
        check("perf_busy_cyc", perf_busy_cyc, busy_cnt);
        if (mode == 0) check("perf_stall_zero", perf_stall_cyc, 0);
        else           check("perf_stall_cyc", perf_stall_cyc, busy_cnt - ref_busy);
`else
        check("perf_busy_tied", perf_busy_cyc, 0);
        check("perf_stall_tied", perf_stall_cyc, 0);
`endif
        if (mode == 1)
            check("toggle_extra_cycles", (busy_cnt - ref_busy >= 315) && (busy_cnt - ref_busy <= 324), 1);
        else if (inject)
            check("tile_len_unchanged", busy_cnt, ref_busy);
        else
            ref_busy = busy_cnt;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ofifo_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_inst", inst, IDLE_INST);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sfp_valid", sfp_valid, 0);
        check("rst_sfp_clr", sfp_clr, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_perf_busy", perf_busy_cyc, 0);
        check("rst_perf_stall", perf_stall_cyc, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("idle_inst_no_start", inst, IDLE_INST);
        check("idle_busy_no_start", busy, 0);

        run_tile(0, 1'b0, 1'b0);
        run_tile(1, 1'b0, 1'b0);
        run_tile(0, 1'b0, 1'b1);
        run_tile(0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
